pc_fetch_ctrl: RTL
==================

Name: pc_fetch_ctrl

Overview:
- Program-counter / fetch-control stage directly upstream of the ALU.
- Consumes the ALU's doBranch result plus decoded branch fields, and produces the instruction-memory address for the next cycle.
- Supports three branch kinds: relative branch (B/BEQ), table-lookup branch (B_LOOKUP) through a small programmable target LUT, and DONE halt.
- Contains a 3-state run-control FSM with a start/done handshake toward the testbench or top level.

Parameters:
- PC_W, 10, program counter width in bits; PC wraps modulo 2^PC_W.
- OFS_W, 6, width of the signed relative branch offset field.
- LUT_DEPTH, 8, number of entries in the branch-target LUT (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; launches a program from address 0.
- stall  in  1  hold PC and suppress the branch this cycle.
- do_branch  in  1  ALU doBranch for the instruction currently at pc.
- is_lookup  in  1  current instruction is B_LOOKUP; target comes from the LUT.
- is_done  in  1  current instruction is DONE.
- br_field  in  OFS_W  signed offset (relative) or LUT index in its low bits (lookup).
- lut_we  in  1  LUT write enable.
- lut_waddr  in  $clog2(LUT_DEPTH)  LUT write index.
- lut_wdata  in  PC_W  LUT write target.
- pc  out  PC_W  instruction-memory address.
- fetch_valid  out  1  high while in RUN; pc is a live fetch address.
- done  out  1  high while in HALT.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=0, fetch_valid=0, done=0.
  - All LUT entries = 0.
  - Counter (if present) = 0.
- FSM states: IDLE, RUN, HALT. State is encoded in a package enum.
  - IDLE: pc holds 0. start -> RUN with pc=0.
  - RUN, in priority order:
    1. start: restart, pc<=0, stay RUN.
    2. stall: pc holds, no state change.
    3. is_done: -> HALT, pc holds the DONE address.
    4. do_branch & is_lookup: pc <= lut[br_field[$clog2(LUT_DEPTH)-1:0]].
    5. do_branch & !is_lookup: pc <= pc + sign_extend(br_field), truncated to PC_W (wraps).
    6. else: pc <= pc + 1, wraps 2^PC_W-1 -> 0.
  - HALT: done=1, fetch_valid=0, pc holds. start -> RUN with pc=0 and done drops the next cycle. Branch, done and stall inputs are ignored in HALT.
- Outputs are registered decodes of state (fetch_valid = state==RUN, done = state==HALT); they change on the same edge as the state.
- Latency: the branch decision in cycle N becomes the pc in cycle N+1. There are no delay slots.
- A relative offset of 0 makes a self-loop (pc unchanged), which is legal.
- LUT:
  - Synchronous write on clk when lut_we=1, accepted in any state.
  - Read is combinational.
  - Write and lookup to the same index in the same cycle: the lookup uses the OLD entry; the new value is visible the next cycle.
- is_lookup without do_branch: treated as fall-through (pc+1).
- Reset asserted mid-RUN: immediate return to IDLE, pc=0. The LUT contents are lost.

Optional Feature:
- Macro: PC_BRANCH_CNT_EN.
- Defined:
  - Adds output port branch_count (16 bits).
  - Increments on every taken branch accepted in RUN (do_branch, not stall, not is_done), saturating at 16'hFFFF.
  - Cleared on reset and on start.
  - Frozen in HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package pc_fetch_pkg:
  - Run-state enum (IDLE, RUN, HALT).
  - Default PC_W/OFS_W/LUT_DEPTH constants.
  - Sign-extension helper function.
- Sub-module branch_lut: LUT_DEPTH x PC_W register array with one sync write port and one async read port, reset to 0.
- The FSM and PC arithmetic stay in the top module.

Test Plan:
- Reset then start; no branches for 5 cycles -> pc sequence 0,1,2,3,4,5; fetch_valid=1, done=0.
- At pc=20, do_branch=1, br_field=6'b111101 (-3) -> next pc=17. At pc=3, br_field=-5 -> pc=2^10-2=1022 (wrap).
- Write lut[2]=300. At pc=7: do_branch=1, is_lookup=1, br_field=2 -> pc=300. In the same cycle also write lut[2]=400 -> pc still 300; the next lookup of index 2 -> 400.
- At pc=50: stall=1 with do_branch=1 for 2 cycles -> pc stays 50. Then release with do_branch=0 -> pc=51.
- At pc=9: is_done=1 together with do_branch=1 -> HALT, pc=9, done=1, fetch_valid=0. Then start -> pc=0, RUN.
- Drop reset_n mid-run at pc=33, off-edge -> pc=0, state IDLE immediately. With PC_BRANCH_CNT_EN defined, branch_count=0 and it counts exactly 3 after 3 taken branches.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared types, default sizes and helpers for the PC fetch stage
//
// Contents:
//   run_state_e    run-control FSM states (IDLE, RUN, HALT)
//   *_DEF          default PC width, branch offset width and target LUT depth
//   sign_extend32  sign-extends the low 'width' bits of a value to 32 bits
package pc_fetch_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int OFS_W_DEF     = 6;
    localparam int LUT_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } run_state_e;

    // Shift the field to the top of the word, then arithmetic-shift it back
    // so the field's MSB fills every upper bit.
    function automatic logic [31:0] sign_extend32(input logic [31:0] val,
                                                  input int unsigned width);
        logic signed [31:0] t;
        t = signed'(val << (32 - width));
        return unsigned'(t >>> (32 - width));
    endfunction

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch-target lookup table, one sync write port, one async read port
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset; clears every entry to 0
//   i_we      write enable
//   i_waddr   write index
//   i_wdata   write data (branch target)
//   i_raddr   read index
//   o_rdata   combinational read data
//
// Same-index write and read in one cycle returns the old entry; the new
// value appears after the clock edge.
module branch_lut #(
    parameter int DEPTH = 8,
    parameter int DW    = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DW-1:0]            i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DW-1:0]            o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and run-control FSM feeding instruction fetch
//
// Ports:
//   clk, reset_n     clock (rising edge) and asynchronous active-low reset
//   start            1-cycle pulse; (re)launches the program at address 0
//   stall            hold pc and ignore the branch this cycle
//   do_branch        branch taken for the instruction at pc
//   is_lookup        branch target comes from the LUT instead of pc+offset
//   is_done          instruction at pc is DONE; enter HALT
//   br_field         signed relative offset, or LUT index in its low bits
//   lut_we/lut_waddr/lut_wdata   LUT write port, accepted in any state
//   pc               instruction-memory address
//   fetch_valid      high while running
//   done             high while halted
//   branch_count     (PC_BRANCH_CNT_EN only) saturating count of taken branches
//
// Optional feature macro: PC_BRANCH_CNT_EN
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int OFS_W     = OFS_W_DEF,
    parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         do_branch,
    input  logic                         is_lookup,
    input  logic                         is_done,
    input  logic [OFS_W-1:0]             br_field,
    input  logic                         lut_we,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
    input  logic [PC_W-1:0]              lut_wdata,
    output logic [PC_W-1:0]              pc,
    output logic                         fetch_valid,
    output logic                         done
`ifdef PC_BRANCH_CNT_EN
    ,
    output logic [15:0]                  branch_count
`endif
);

    localparam int LUT_AW = $clog2(LUT_DEPTH);

    run_state_e      r_state;
    run_state_e      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_rel;
    logic [PC_W-1:0] w_lut_rdata;
    logic [31:0]     w_ofs_ext;
    logic            r_fetch_valid;
    logic            r_done;
    logic            w_branch_taken;
    logic            w_cnt_clear;

    branch_lut #(
        .DEPTH (LUT_DEPTH),
        .DW    (PC_W)
    ) u_branch_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (lut_we),
        .i_waddr (lut_waddr),
        .i_wdata (lut_wdata),
        .i_raddr (br_field[LUT_AW-1:0]),
        .o_rdata (w_lut_rdata)
    );

    // Relative target: add in 32 bits then truncate, giving modulo-2^PC_W wrap.
    assign w_ofs_ext = sign_extend32(32'(br_field), OFS_W);
    assign w_pc_rel  = PC_W'(32'(r_pc) + w_ofs_ext);
    assign w_pc_inc  = r_pc + PC_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_branch_taken = 1'b0;
        w_cnt_clear    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
                    w_cnt_clear = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_cnt_clear = 1'b1;
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (is_done) begin
                    w_state_nxt = HALT;
                end else if (do_branch) begin
                    w_branch_taken = 1'b1;
                    w_pc_nxt       = is_lookup ? w_lut_rdata : w_pc_rel;
                end else begin
                    w_pc_nxt = w_pc_inc;
                end
            end
            HALT: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_pc_nxt    = '0;
                    w_cnt_clear = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they switch on
    // the same edge as the state itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_fetch_valid <= (w_state_nxt == RUN);
            r_done        <= (w_state_nxt == HALT);
        end
    end

    assign pc          = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign done        = r_done;

`ifdef PC_BRANCH_CNT_EN
    logic [15:0] r_branch_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_branch_count <= '0;
        end else if (w_cnt_clear) begin
            r_branch_count <= '0;
        end else if (w_branch_taken && (r_branch_count != 16'hFFFF)) begin
            r_branch_count <= r_branch_count + 16'd1;
        end
    end

    assign branch_count = r_branch_count;
`else
    logic w_unused_cnt;
    assign w_unused_cnt = w_branch_taken ^ w_cnt_clear;
`endif

endmodule
